// File: rtl/mux8_serializer.sv
// Parallel-to-serial front end for an external 8:1 mux: holds a loaded word on mux_in,
// walks mux_sel across all bit positions and forwards mux_y as a valid/ready serial stream.
module mux8_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    output logic [7:0] mux_in,
    output logic [2:0] mux_sel,
    input  logic       mux_y,
    output logic       ser_data,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_last,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t     state, state_next;
    logic [7:0] word, word_next;
    logic [2:0] cnt, cnt_next;
    logic       beat;
    logic       load;
    logic       last_pos;

    assign mux_in    = word;
    assign mux_sel   = MSB_FIRST ? (3'd7 - cnt) : cnt;
    assign ser_data  = mux_y;
    assign ser_valid = (state == SHIFT);
    assign busy      = ser_valid;
    assign last_pos  = (cnt == 3'd7);
    assign ser_last  = ser_valid & last_pos;
    assign beat      = ser_valid & ser_ready;
    // A word may be taken while the previous one drains its final bit, so streams chain without a gap.
    assign load_ready = !rst & ((state == IDLE) | (beat & last_pos));
    assign load       = load_valid & load_ready;

    always_comb begin
        state_next = state;
        word_next  = word;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    word_next  = load_data;
                    cnt_next   = 3'd0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (!last_pos) begin
                        cnt_next = cnt + 3'd1;
                    end else if (load) begin
                        word_next = load_data;
                        cnt_next  = 3'd0;
                    end else begin
                        cnt_next   = 3'd0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            word  <= 8'd0;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            word  <= word_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mux8_serializer.sv
// Bench for mux8_serializer: both bit orders run side by side on shared stimulus, with a
// beat scoreboard filled on predicted acceptance and drained on each predicted beat.
module tb_mux8_serializer;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       ser_ready;

    logic       load_ready0, load_ready1;
    logic [7:0] mux_in0, mux_in1;
    logic [2:0] mux_sel0, mux_sel1;
    logic       mux_y0, mux_y1;
    logic       ser_data0, ser_data1;
    logic       ser_valid0, ser_valid1;
    logic       ser_last0, ser_last1;
    logic       busy0, busy1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       b0;
        logic       b1;
        logic [2:0] s0;
        logic [2:0] s1;
        logic       last;
    } beat_t;

    beat_t      sb[$];
    logic [7:0] model_word = 8'd0;

    mux8_serializer #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready0), .load_data(load_data),
        .mux_in(mux_in0), .mux_sel(mux_sel0), .mux_y(mux_y0),
        .ser_data(ser_data0), .ser_valid(ser_valid0), .ser_ready(ser_ready),
        .ser_last(ser_last0), .busy(busy0)
    );

    mux8_serializer #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready1), .load_data(load_data),
        .mux_in(mux_in1), .mux_sel(mux_sel1), .mux_y(mux_y1),
        .ser_data(ser_data1), .ser_valid(ser_valid1), .ser_ready(ser_ready),
        .ser_last(ser_last1), .busy(busy1)
    );

    // Behavioural stand-in for the external 8:1 mux
    assign mux_y0 = mux_in0[mux_sel0];
    assign mux_y1 = mux_in1[mux_sel1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic lv, input logic [7:0] ld, input logic sr);
        @(posedge clk);
        #1;
        rst        = r;
        load_valid = lv;
        load_data  = ld;
        ser_ready  = sr;
    endtask

    // Compare in mid-cycle, then advance the scoreboard as the coming edge will
    always @(negedge clk) begin
        logic  exp_ready;
        logic  exp_valid;
        beat_t b;
        exp_valid = (sb.size() != 0);
        exp_ready = !rst && (sb.size() == 0 || (sb.size() == 1 && ser_ready));

        checkOutput("load_ready0", 32'(load_ready0), 32'(exp_ready));
        checkOutput("load_ready1", 32'(load_ready1), 32'(exp_ready));
        checkOutput("ser_valid0", 32'(ser_valid0), 32'(exp_valid));
        checkOutput("ser_valid1", 32'(ser_valid1), 32'(exp_valid));
        checkOutput("busy0", 32'(busy0), 32'(exp_valid));
        checkOutput("busy1", 32'(busy1), 32'(exp_valid));
        checkOutput("mux_in0", 32'(mux_in0), 32'(model_word));
        checkOutput("mux_in1", 32'(mux_in1), 32'(model_word));

        if (exp_valid) begin
            b = sb[0];
            checkOutput("ser_data0", 32'(ser_data0), 32'(b.b0));
            checkOutput("ser_data1", 32'(ser_data1), 32'(b.b1));
            checkOutput("mux_sel0", 32'(mux_sel0), 32'(b.s0));
            checkOutput("mux_sel1", 32'(mux_sel1), 32'(b.s1));
            checkOutput("ser_last0", 32'(ser_last0), 32'(b.last));
            checkOutput("ser_last1", 32'(ser_last1), 32'(b.last));
        end else begin
            checkOutput("idle_sel0", 32'(mux_sel0), 32'd0);
            checkOutput("idle_sel1", 32'(mux_sel1), 32'd7);
            checkOutput("idle_last0", 32'(ser_last0), 32'd0);
            checkOutput("idle_last1", 32'(ser_last1), 32'd0);
        end

        if (rst) begin
            sb.delete();
            model_word = 8'd0;
        end else begin
            if (exp_valid && ser_ready) void'(sb.pop_front());
            if (load_valid && exp_ready) begin
                model_word = load_data;
                for (int k = 0; k < 8; k++) begin
                    b.b0   = load_data[k];
                    b.b1   = load_data[7-k];
                    b.s0   = 3'(k);
                    b.s1   = 3'(7 - k);
                    b.last = (k == 7);
                    sb.push_back(b);
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        ser_ready  = 1'b1;

        // Reset held two cycles, with a word offered that must not be taken
        applyStimulus(1'b1, 1'b1, 8'hC3, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        idleCycles(2);

        // Single word, full-rate drain
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
        idleCycles(10);

        // Back-to-back words; the second is offered throughout the first
        applyStimulus(1'b0, 1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1);
        idleCycles(10);

        // Stall for three cycles at cnt=2
        applyStimulus(1'b0, 1'b1, 8'hF0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        idleCycles(9);

        // Word offered mid-stream from cnt=3 until the last beat
        applyStimulus(1'b0, 1'b1, 8'h11, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        idleCycles(10);

        // Abort at cnt=4 with a competing load, then a clean restart
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h0F, 1'b1);
        idleCycles(10);

        // Random traffic with backpressure
        for (int i = 0; i < 150; i++)
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 3) != 0));

        // Bounded drain of whatever is still in flight
        for (int i = 0; i < 60 && sb.size() != 0; i++) idleCycles(1);
        @(negedge clk);
        #1;
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
